// File: rtl/pipe_skid_latch_pkg.sv
// Shared pipeline-stage definitions: occupancy encoding, default bubble
// instruction and the default-width entry record.
package pipe_skid_latch_pkg;

  localparam int unsigned OCC_W     = 2;
  localparam int unsigned DEF_INSN_W = 32;
  localparam int unsigned DEF_RES_W  = 32;

  // Occupancy of the stage latch; the encoding is also the o_count value.
  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam logic [DEF_INSN_W-1:0] NOP_INSN_DEFAULT = 32'h0000_0000;

  // Default-width entry record {valid, insn, result, MD_rdy}.
  typedef struct packed {
    logic                  valid;
    logic [DEF_INSN_W-1:0] insn;
    logic [DEF_RES_W-1:0]  result;
    logic                  md_rdy;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// Single pipeline entry register with load enable, synchronous clear and a
// selectable clock edge.
//   clk_i  : stage clock (edge chosen by FALLING_EDGE)
//   clr_i  : synchronous clear, wins over en_i
//   en_i   : load d_i
//   d_i    : next entry contents
//   q_o    : held entry contents
module pipe_entry_reg
  import pipe_skid_latch_pkg::*;
#(
  parameter int unsigned W            = 1,
  parameter bit          FALLING_EDGE = 1'b1
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Same update rule on whichever edge the stage runs on.
  generate
    if (FALLING_EDGE) begin : g_neg
      always_ff @(negedge clk_i) begin
        if (clr_i)     q_q <= '0;
        else if (en_i) q_q <= d_i;
      end
    end else begin : g_pos
      always_ff @(posedge clk_i) begin
        if (clr_i)     q_q <= '0;
        else if (en_i) q_q <= d_i;
      end
    end
  endgenerate

  assign q_o = q_q;

endmodule

// File: rtl/pipe_skid_latch.sv
// Inter-stage pipeline latch with valid/ready flow control and a 2-entry
// skid buffer (main + skid). o_ready depends only on registered state.
//   clock, reset, flush        : stage clock, sync reset, sync flush
//   i_valid/o_ready, i_insn,
//   i_result, i_MD_rdy         : upstream handshake and payload
//   o_valid/i_ready, o_insn,
//   o_result, o_MD_rdy         : downstream handshake and payload
//   o_count                    : occupancy 0..2
module pipe_skid_latch
  import pipe_skid_latch_pkg::*;
#(
  parameter int unsigned           INSN_W       = 32,
  parameter int unsigned           RES_W        = 32,
  parameter bit                    FALLING_EDGE = 1'b1,
  parameter logic [INSN_W-1:0]     NOP_INSN     = INSN_W'(NOP_INSN_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [INSN_W-1:0] i_insn,
  input  logic [RES_W-1:0]  i_result,
  input  logic              i_MD_rdy,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [INSN_W-1:0] o_insn,
  output logic [RES_W-1:0]  o_result,
  output logic              o_MD_rdy,
  output logic [OCC_W-1:0]  o_count
);

  typedef struct packed {
    logic              valid;
    logic [INSN_W-1:0] insn;
    logic [RES_W-1:0]  result;
    logic              md_rdy;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  occ_e   state_q, state_d;
  entry_t in_e, main_q, main_d, skid_q, skid_d;
  logic   main_en, skid_en, clr_c;
  logic   accept_c, retire_c;

  assign in_e     = '{valid: 1'b1, insn: i_insn, result: i_result, md_rdy: i_MD_rdy};
  assign clr_c    = reset | flush;
  assign accept_c = i_valid & o_ready;
  assign retire_c = o_valid & i_ready;

  // Occupancy state register on the selected edge.
  generate
    if (FALLING_EDGE) begin : g_neg
      always_ff @(negedge clock) begin
        if (clr_c) state_q <= OCC_EMPTY;
        else       state_q <= state_d;
      end
    end else begin : g_pos
      always_ff @(posedge clock) begin
        if (clr_c) state_q <= OCC_EMPTY;
        else       state_q <= state_d;
      end
    end
  endgenerate

  // Next state and entry load control; vacated entries are loaded with zero.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_e;
    skid_d  = in_e;
    case (state_q)
      OCC_EMPTY: begin
        if (accept_c) begin
          main_en = 1'b1;
          state_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept_c && retire_c) begin
          main_en = 1'b1;
        end else if (accept_c) begin
          skid_en = 1'b1;
          state_d = OCC_FULL;
        end else if (retire_c) begin
          main_en = 1'b1;
          main_d  = '0;
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (retire_c) begin
          main_en = 1'b1;
          main_d  = skid_q;
          skid_en = 1'b1;
          skid_d  = '0;
          state_d = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  pipe_entry_reg #(.W(ENTRY_W), .FALLING_EDGE(FALLING_EDGE)) u_main (
    .clk_i (clock),
    .clr_i (clr_c),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  pipe_entry_reg #(.W(ENTRY_W), .FALLING_EDGE(FALLING_EDGE)) u_skid (
    .clk_i (clock),
    .clr_i (clr_c),
    .en_i  (skid_en),
    .d_i   (skid_d),
    .q_o   (skid_q)
  );

  // Outputs come straight from registers; bubbles are masked to NOP/zero.
  assign o_ready  = ~skid_q.valid;
  assign o_valid  = main_q.valid;
  assign o_insn   = main_q.valid ? main_q.insn : NOP_INSN;
  assign o_result = main_q.valid ? main_q.result : '0;
  assign o_MD_rdy = main_q.valid & main_q.md_rdy;
  assign o_count  = OCC_W'(state_q);

endmodule

// File: tb/tb_pipe_skid_latch.sv
module tb_pipe_skid_latch;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // Default instance: 32/32, falling edge, NOP = 0
  logic        reset, flush, i_valid, i_ready, i_MD_rdy;
  logic [31:0] i_insn, i_result;
  logic        o_ready, o_valid, o_MD_rdy;
  logic [31:0] o_insn, o_result;
  logic [1:0]  o_count;

  // Swept instance: 16/64, rising edge, NOP = 0x0013
  logic        reset2, flush2, i_valid2, i_ready2, i_MD_rdy2;
  logic [15:0] i_insn2;
  logic [63:0] i_result2;
  logic        o_ready2, o_valid2, o_MD_rdy2;
  logic [15:0] o_insn2;
  logic [63:0] o_result2;
  logic [1:0]  o_count2;

  int checks = 0;
  int errors = 0;

  pipe_skid_latch dut (
    .clock(clock), .reset(reset), .flush(flush),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_insn(i_insn), .i_result(i_result), .i_MD_rdy(i_MD_rdy),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_insn(o_insn), .o_result(o_result), .o_MD_rdy(o_MD_rdy),
    .o_count(o_count)
  );

  pipe_skid_latch #(
    .INSN_W(16), .RES_W(64), .FALLING_EDGE(1'b0), .NOP_INSN(16'h0013)
  ) dut2 (
    .clock(clock), .reset(reset2), .flush(flush2),
    .i_valid(i_valid2), .o_ready(o_ready2),
    .i_insn(i_insn2), .i_result(i_result2), .i_MD_rdy(i_MD_rdy2),
    .o_valid(o_valid2), .i_ready(i_ready2),
    .o_insn(o_insn2), .o_result(o_result2), .o_MD_rdy(o_MD_rdy2),
    .o_count(o_count2)
  );

  // Advance past one active (falling) edge of the default instance.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] insn, input logic [31:0] res, input logic md);
    i_valid  = 1'b1;
    i_insn   = insn;
    i_result = res;
    i_MD_rdy = md;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if (o_count !== 2'd0 || o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_init: count=%0d valid=%b ready=%b, want 0/0/1", o_count, o_valid, o_ready); end
    push(32'h51, 32'h151, 1'b1); tick();
    push(32'h52, 32'h152, 1'b0); tick();
    checks++; if (o_count !== 2'd2 || o_insn !== 32'h51 || o_MD_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_fill: count=%0d insn=%h md=%b, want 2/51/1", o_count, o_insn, o_MD_rdy); end
    reset = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_count !== 2'd0) begin
      errors++; $display("FAIL reset_mid_ctrl: valid=%b ready=%b count=%0d, want 0/1/0", o_valid, o_ready, o_count); end
    checks++; if (o_insn !== 32'h0 || o_result !== 32'h0 || o_MD_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_data: insn=%h res=%h md=%b, want 0/0/0", o_insn, o_result, o_MD_rdy); end
    reset = 1'b0; i_valid = 1'b0;
    tick();
    checks++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin
      errors++; $display("FAIL reset_after: valid=%b count=%0d, want 0/0", o_valid, o_count); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_insn;
    i_ready = 1'b1;
    push(32'h11, 32'h111, 1'b0);
    // Nothing may change on the rising edge for a falling-edge stage.
    @(posedge clock); #1;
    checks++; if (o_valid !== 1'b0) begin
      errors++; $display("FAIL stream_edge: valid=%b after rising edge, want 0", o_valid); end
    for (int k = 0; k < 8; k++) begin
      exp_insn = 32'h11 + 32'(k);
      push(exp_insn, exp_insn + 32'h100, k[0]);
      tick();
      checks++; if (o_valid !== 1'b1 || o_insn !== exp_insn || o_result !== exp_insn + 32'h100
                    || o_MD_rdy !== k[0] || o_count !== 2'd1 || o_ready !== 1'b1) begin
        errors++; $display("FAIL stream_%0d: valid=%b insn=%h res=%h md=%b count=%0d ready=%b, want 1/%h/%h/%b/1/1",
                           k, o_valid, o_insn, o_result, o_MD_rdy, o_count, o_ready,
                           exp_insn, exp_insn + 32'h100, k[0]); end
    end
    i_valid = 1'b0;
    tick();
    checks++; if (o_valid !== 1'b0 || o_count !== 2'd0 || o_insn !== 32'h0) begin
      errors++; $display("FAIL stream_drain: valid=%b count=%0d insn=%h, want 0/0/0", o_valid, o_count, o_insn); end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    push(32'hA1, 32'h1A1, 1'b1); tick();
    checks++; if (o_count !== 2'd1 || o_ready !== 1'b1 || o_insn !== 32'hA1) begin
      errors++; $display("FAIL bp_one: count=%0d ready=%b insn=%h, want 1/1/A1", o_count, o_ready, o_insn); end
    push(32'hA2, 32'h1A2, 1'b0); tick();
    checks++; if (o_count !== 2'd2 || o_ready !== 1'b0 || o_insn !== 32'hA1) begin
      errors++; $display("FAIL bp_full: count=%0d ready=%b insn=%h, want 2/0/A1", o_count, o_ready, o_insn); end
    push(32'hA3, 32'h1A3, 1'b1); tick();
    checks++; if (o_count !== 2'd2 || o_insn !== 32'hA1 || o_result !== 32'h1A1 || o_MD_rdy !== 1'b1) begin
      errors++; $display("FAIL bp_hold: count=%0d insn=%h res=%h md=%b, want 2/A1/1A1/1", o_count, o_insn, o_result, o_MD_rdy); end
    i_ready = 1'b1; tick();
    checks++; if (o_insn !== 32'hA2 || o_result !== 32'h1A2 || o_count !== 2'd1 || o_ready !== 1'b1) begin
      errors++; $display("FAIL bp_a2: insn=%h res=%h count=%0d ready=%b, want A2/1A2/1/1", o_insn, o_result, o_count, o_ready); end
    tick();
    checks++; if (o_insn !== 32'hA3 || o_result !== 32'h1A3 || o_MD_rdy !== 1'b1 || o_count !== 2'd1) begin
      errors++; $display("FAIL bp_a3: insn=%h res=%h md=%b count=%0d, want A3/1A3/1/1", o_insn, o_result, o_MD_rdy, o_count); end
    i_valid = 1'b0; tick();
    checks++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin
      errors++; $display("FAIL bp_drain: valid=%b count=%0d, want 0/0", o_valid, o_count); end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    push(32'hD1, 32'h1D1, 1'b0); tick();
    push(32'hD2, 32'h1D2, 1'b0); tick();
    checks++; if (o_count !== 2'd2) begin
      errors++; $display("FAIL flush_fill: count=%0d, want 2", o_count); end
    push(32'hB0, 32'h1B0, 1'b1); flush = 1'b1; tick();
    checks++; if (o_count !== 2'd0 || o_valid !== 1'b0 || o_ready !== 1'b1 || o_insn !== 32'h0) begin
      errors++; $display("FAIL flush_full: count=%0d valid=%b ready=%b insn=%h, want 0/0/1/0", o_count, o_valid, o_ready, o_insn); end
    flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1; tick();
    checks++; if (o_valid !== 1'b0 || o_count !== 2'd0) begin
      errors++; $display("FAIL flush_drop: valid=%b count=%0d, want 0/0", o_valid, o_count); end
  endtask

  task automatic test_accept_retire();
    i_ready = 1'b0;
    push(32'hC1, 32'h1C1, 1'b0); tick();
    checks++; if (o_insn !== 32'hC1 || o_count !== 2'd1) begin
      errors++; $display("FAIL ar_load: insn=%h count=%0d, want C1/1", o_insn, o_count); end
    i_ready = 1'b1;
    push(32'hC2, 32'h1C2, 1'b1); tick();
    checks++; if (o_insn !== 32'hC2 || o_count !== 2'd1 || o_ready !== 1'b1 || o_MD_rdy !== 1'b1) begin
      errors++; $display("FAIL ar_swap: insn=%h count=%0d ready=%b md=%b, want C2/1/1/1", o_insn, o_count, o_ready, o_MD_rdy); end
    i_valid = 1'b0; tick();
    checks++; if (o_valid !== 1'b0 || o_count !== 2'd0 || o_insn !== 32'h0) begin
      errors++; $display("FAIL ar_drain: valid=%b count=%0d insn=%h, want 0/0/0", o_valid, o_count, o_insn); end
  endtask

  task automatic test_param_sweep();
    reset2 = 1'b1;
    @(posedge clock); #1;
    reset2 = 1'b0;
    checks++; if (o_valid2 !== 1'b0 || o_insn2 !== 16'h0013 || o_result2 !== 64'h0 || o_count2 !== 2'd0) begin
      errors++; $display("FAIL p_reset: valid=%b insn=%h res=%h count=%0d, want 0/0013/0/0", o_valid2, o_insn2, o_result2, o_count2); end
    i_valid2 = 1'b1; i_insn2 = 16'h1234; i_result2 = 64'hDEAD_BEEF_0123_4567; i_MD_rdy2 = 1'b1; i_ready2 = 1'b0;
    @(negedge clock); #1;
    checks++; if (o_valid2 !== 1'b0 || o_count2 !== 2'd0) begin
      errors++; $display("FAIL p_negedge_load: valid=%b count=%0d, want 0/0", o_valid2, o_count2); end
    @(posedge clock); #1;
    checks++; if (o_valid2 !== 1'b1 || o_insn2 !== 16'h1234 || o_result2 !== 64'hDEAD_BEEF_0123_4567 || o_MD_rdy2 !== 1'b1) begin
      errors++; $display("FAIL p_load: valid=%b insn=%h res=%h md=%b, want 1/1234/DEADBEEF01234567/1", o_valid2, o_insn2, o_result2, o_MD_rdy2); end
    i_valid2 = 1'b0; i_ready2 = 1'b1;
    @(negedge clock); #1;
    checks++; if (o_valid2 !== 1'b1 || o_insn2 !== 16'h1234) begin
      errors++; $display("FAIL p_negedge_hold: valid=%b insn=%h, want 1/1234", o_valid2, o_insn2); end
    @(posedge clock); #1;
    checks++; if (o_valid2 !== 1'b0 || o_insn2 !== 16'h0013 || o_result2 !== 64'h0 || o_MD_rdy2 !== 1'b0) begin
      errors++; $display("FAIL p_bubble: valid=%b insn=%h res=%h md=%b, want 0/0013/0/0", o_valid2, o_insn2, o_result2, o_MD_rdy2); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_insn = '0; i_result = '0; i_MD_rdy = 1'b0;
    reset2 = 1'b1; flush2 = 1'b0; i_valid2 = 1'b0; i_ready2 = 1'b0;
    i_insn2 = '0; i_result2 = '0; i_MD_rdy2 = 1'b0;
    #2;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_accept_retire();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
